// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state codes, lamp patterns and duration helper
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_G   = 3'd0,
    MAIN_Y   = 3'd1,
    ALLRED_A = 3'd2,
    SIDE_G   = 3'd3,
    SIDE_Y   = 3'd4,
    ALLRED_B = 3'd5
  } state_t;

  localparam logic [2:0] LT_R = 3'b100;
  localparam logic [2:0] LT_Y = 3'b010;
  localparam logic [2:0] LT_G = 3'b001;

  // A zero-length phase would never expire, so it is stretched to one cycle.
  function automatic int unsigned min_one(input int unsigned t);
    return (t == 0) ? 1 : t;
  endfunction

endpackage

// File: rtl/traffic_phase_sequencer_timer.sv
// rtl/traffic_phase_sequencer_timer.sv - loadable phase down-counter that parks at 1
module phase_timer #(
  parameter int unsigned W = 11,
  parameter logic [W-1:0] INIT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic [W-1:0] remaining,
  output logic         expired
);

  // Count down while enabled; a load takes priority, and 1 is held until reloaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining <= INIT;
    end else if (en) begin
      if (load) begin
        remaining <= value;
      end else if (remaining > W'(1)) begin
        remaining <= remaining - W'(1);
      end
    end
  end

  assign expired = (remaining == W'(1));

endmodule

// File: rtl/traffic_phase_sequencer.sv
// rtl/traffic_phase_sequencer.sv - two-road phase controller with pedestrian walk
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned W        = 11,
  parameter int unsigned T_GMIN   = 15,
  parameter int unsigned T_YEL    = 2,
  parameter int unsigned T_ALLRED = 1,
  parameter int unsigned T_SIDE   = 12,
  parameter int unsigned T_WALK   = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         car_side,
  input  logic         ped_req,
  output logic [2:0]   main_lt,
  output logic [2:0]   side_lt,
  output logic         walk,
  output logic [2:0]   phase,
  output logic [W-1:0] remaining,
  output logic         ped_pending
);

  localparam logic [W-1:0] D_GMIN   = W'(min_one(T_GMIN));
  localparam logic [W-1:0] D_YEL    = W'(min_one(T_YEL));
  localparam logic [W-1:0] D_ALLRED = W'(min_one(T_ALLRED));
  localparam logic [W-1:0] D_SIDE   = W'(min_one(T_SIDE));
  localparam logic [W-1:0] D_WALK   = W'(min_one(T_WALK));

  state_t       state, next_state;
  logic         load;
  logic [W-1:0] load_value;
  logic         expired;
  logic         capture;
  logic         walk_next;
  logic         walk_q;
  logic         pend_q;

  phase_timer #(.W(W), .INIT(D_ALLRED)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .value     (load_value),
    .en        (enable),
    .remaining (remaining),
    .expired   (expired)
  );

  // Advance on expiry of an enabled cycle and load the next phase's duration.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_value = D_GMIN;
    capture    = 1'b0;
    walk_next  = pend_q | ped_req;
    if (enable && expired) begin
      case (state)
        MAIN_G: begin
          if (car_side || pend_q) begin
            next_state = MAIN_Y;
            load       = 1'b1;
            load_value = D_YEL;
          end
        end
        MAIN_Y: begin
          next_state = ALLRED_A;
          load       = 1'b1;
          load_value = D_ALLRED;
        end
        ALLRED_A: begin
          next_state = SIDE_G;
          load       = 1'b1;
          capture    = 1'b1;
          load_value = walk_next ? D_WALK : D_SIDE;
        end
        SIDE_G: begin
          next_state = SIDE_Y;
          load       = 1'b1;
          load_value = D_YEL;
        end
        SIDE_Y: begin
          next_state = ALLRED_B;
          load       = 1'b1;
          load_value = D_ALLRED;
        end
        ALLRED_B: begin
          next_state = MAIN_G;
          load       = 1'b1;
          load_value = D_GMIN;
        end
        default: begin
          next_state = ALLRED_B;
          load       = 1'b1;
          load_value = D_ALLRED;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ALLRED_B;
    else       state <= next_state;
  end

  // Walk decision is frozen at side-green entry for the whole side-green phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        walk_q <= 1'b0;
    else if (capture) walk_q <= walk_next;
  end

  // Pedestrian latch: set by any request, cleared only when a walk is served.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        pend_q <= 1'b0;
    else if (capture) pend_q <= 1'b0;
    else if (ped_req) pend_q <= 1'b1;
  end

  // Lamp decode purely from registered state.
  always_comb begin
    main_lt = LT_R;
    side_lt = LT_R;
    case (state)
      MAIN_G:  main_lt = LT_G;
      MAIN_Y:  main_lt = LT_Y;
      SIDE_G:  side_lt = LT_G;
      SIDE_Y:  side_lt = LT_Y;
      default: ;
    endcase
  end

  assign walk        = walk_q && (state == SIDE_G);
  assign phase       = state;
  assign ped_pending = pend_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb/tb_traffic_phase_sequencer.sv - scoreboard bench for traffic_phase_sequencer
module tb_traffic_phase_sequencer;

  localparam int W = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic          car_side = 1'b0;
  logic          ped_req = 1'b0;
  logic [2:0]    main_lt, side_lt, phase;
  logic          walk, ped_pending;
  logic [W-1:0]  remaining;

  int n_checks = 0;
  int n_pass = 0;
  int cyc_n = 0;

  // Reference model state
  int m_state, m_rem;
  bit m_w, m_pend;
  logic [21:0] exp_q[$];

  traffic_phase_sequencer #(
    .W(W), .T_GMIN(4), .T_YEL(2), .T_ALLRED(1), .T_SIDE(3), .T_WALK(5)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .car_side(car_side),
    .ped_req(ped_req), .main_lt(main_lt), .side_lt(side_lt), .walk(walk),
    .phase(phase), .remaining(remaining), .ped_pending(ped_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [21:0] observed();
    return {main_lt, side_lt, walk, phase, remaining, ped_pending};
  endfunction

  function automatic logic [21:0] model_outs();
    logic [2:0] ml, sl;
    ml = 3'b100;
    sl = 3'b100;
    case (m_state)
      0: ml = 3'b001;
      1: ml = 3'b010;
      3: sl = 3'b001;
      4: sl = 3'b010;
      default: ;
    endcase
    return {ml, sl, (m_state == 3) && m_w, 3'(m_state), 11'(m_rem), m_pend};
  endfunction

  task automatic model_reset();
    m_state = 5;
    m_rem = 1;
    m_w = 0;
    m_pend = 0;
  endtask

  task automatic model_step(input bit en, input bit car, input bit ped);
    bit served;
    served = 0;
    if (en) begin
      if (m_rem > 1) begin
        m_rem--;
      end else begin
        case (m_state)
          0: if (car || m_pend) begin m_state = 1; m_rem = 2; end
          1: begin m_state = 2; m_rem = 1; end
          2: begin m_state = 3; m_w = m_pend | ped; m_rem = m_w ? 5 : 3; served = 1; end
          3: begin m_state = 4; m_rem = 2; end
          4: begin m_state = 5; m_rem = 1; end
          default: begin m_state = 0; m_rem = 4; end
        endcase
      end
    end
    if (served) m_pend = 0;
    else if (ped) m_pend = 1;
  endtask

  task automatic cycle(input bit en, input bit car, input bit ped);
    enable = en;
    car_side = car;
    ped_req = ped;
    model_step(en, car, ped);
    exp_q.push_back(model_outs());
    @(posedge clk);
    #1;
    cyc_n++;
    if (exp_q.size() > 0) check($sformatf("cyc%0d", cyc_n), 32'(observed()), 32'(exp_q.pop_front()));
  endtask

  initial begin
    bit found;
    int t_first, t_second, n_walk, walk_seen;
    logic [2:0] prev;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_phase", phase, 3'd5);
    check("rst_remaining", remaining, 1);
    check("rst_main_lt", main_lt, 3'b100);
    check("rst_side_lt", side_lt, 3'b100);
    check("rst_walk", walk, 0);
    check("rst_pend", ped_pending, 0);
    model_reset();
    reset = 1'b0;

    // 1: no demand, MAIN_G counts 4..1 then parks at 1
    for (int i = 0; i < 50; i++) begin
      cycle(1, 0, 0);
      if (i == 0) check("t1_first_main_g", {phase, remaining}, {3'd0, 11'd4});
      if (i == 3) check("t1_expired", {phase, remaining}, {3'd0, 11'd1});
    end
    check("t1_parked", {phase, remaining}, {3'd0, 11'd1});

    // 2: car_side held, 13-cycle loop, no walk
    t_first = -1;
    t_second = -1;
    walk_seen = 0;
    prev = phase;
    for (int i = 0; i < 40 && t_second < 0; i++) begin
      cycle(1, 1, 0);
      if (walk) walk_seen++;
      if (phase == 3'd1 && prev != 3'd1) begin
        if (t_first < 0) t_first = i;
        else t_second = i;
      end
      if (i == 0) check("t2_demand_latency", phase, 3'd1);
      prev = phase;
    end
    check("t2_period", t_second - t_first, 13);
    check("t2_no_walk", walk_seen, 0);

    // 3: ped pulse during expired MAIN_G, walk side green of 5 cycles
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(1, 0, 0);
      if (phase == 3'd0 && remaining == 1) found = 1;
    end
    check("t3_reach_main_g", found, 1);
    cycle(1, 0, 1);
    check("t3_pend_set", {phase, ped_pending}, {3'd0, 1'b1});
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1, 0, 0);
      if (phase == 3'd3) found = 1;
    end
    check("t3_side_g_entry", {walk, ped_pending}, {1'b1, 1'b0});
    n_walk = 1;
    for (int i = 0; i < 10 && phase == 3'd3; i++) begin
      cycle(1, 0, 0);
      if (phase == 3'd3 && walk) n_walk++;
    end
    check("t3_walk_len", n_walk, 5);

    // 4: ped on the exact ALLRED_A->SIDE_G edge, then again inside SIDE_G
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(1, 1, 0);
      if (phase == 3'd2) found = 1;
    end
    check("t4_reach_allred_a", found, 1);
    cycle(1, 1, 1);
    check("t4_served", {phase, walk, ped_pending}, {3'd3, 1'b1, 1'b0});
    cycle(1, 1, 1);
    check("t4_pend_in_side_g", ped_pending, 1);
    cycle(1, 1, 0);
    check("t4_pend_carried", ped_pending, 1);

    // 5: freeze in MAIN_Y at remaining=2
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(1, 1, 0);
      if (phase == 3'd1 && remaining == 2) found = 1;
    end
    check("t5_reach_main_y", found, 1);
    for (int i = 0; i < 7; i++) begin
      cycle(0, 1, 0);
      check("t5_frozen", {phase, remaining}, {3'd1, 11'd2});
    end
    cycle(1, 1, 0);
    check("t5_resume", {phase, remaining}, {3'd1, 11'd1});
    cycle(1, 1, 0);
    check("t5_leave", phase, 3'd2);

    // 6: async reset during walk side green
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(1, 1, i == 0);
      if (phase == 3'd3 && walk) found = 1;
    end
    check("t6_reach_walk", found, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_reset", {main_lt, side_lt, walk, ped_pending, phase, remaining},
          {3'b100, 3'b100, 1'b0, 1'b0, 3'd5, 11'd1});
    @(posedge clk);
    #1;
    reset = 1'b0;
    car_side = 1'b0;
    ped_req = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) cycle(1, 0, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_phase_sequencer.md
# traffic_phase_sequencer

Moore-style phase controller for a two-road intersection: main road and side road, with a side-road car sensor and a pedestrian push-button. It sequences green, yellow and all-red phases using an internal loadable phase timer. It holds main green until demand appears and serves a latched pedestrian request with a walk interval during side green. It sits between the sensor/button synchronisers and the lamp drivers and countdown display.

## Interface
- W, 11: phase-timer width.
- T_GMIN, 15: minimum main-green cycles.
- T_YEL, 2: yellow cycles (both roads).
- T_ALLRED, 1: all-red clearance cycles.
- T_SIDE, 12: side-green cycles without walk.
- T_WALK, 20: side-green cycles with walk.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  0 freezes state and timer.
- car_side  in  1  side-road demand level, already synchronised.
- ped_req  in  1  pedestrian request pulse, already synchronised.
- main_lt  out  3  {R,Y,G} one-hot.
- side_lt  out  3  {R,Y,G} one-hot.
- walk  out  1  walk lamp.
- phase  out  3  current state code.
- remaining  out  W  cycles left in current phase, including the current cycle.
- ped_pending  out  1  pedestrian request latched, not yet served.

## Operation
- States: MAIN_G, MAIN_Y, ALLRED_A, SIDE_G, SIDE_Y, ALLRED_B.
- Entering a state loads the timer with that state's duration. Durations: MAIN_G=T_GMIN, MAIN_Y/SIDE_Y=T_YEL, ALLRED_*=T_ALLRED, SIDE_G=T_WALK if walk else T_SIDE.
- A duration parameter of 0 is treated as 1.
- Each enabled cycle: if remaining>1, decrement. If remaining==1, the phase has expired.
- Transitions on expiry:
  - MAIN_G→MAIN_Y only if car_side or ped_pending. Otherwise MAIN_G holds with remaining held at 1, indefinitely.
  - MAIN_Y→ALLRED_A→SIDE_G→SIDE_Y→ALLRED_B→MAIN_G.
- Lamps:
  - MAIN_G: main G, side R.
  - MAIN_Y: main Y, side R.
  - SIDE_G: main R, side G.
  - SIDE_Y: main R, side Y.
  - ALLRED_*: both R.
  - walk=1 only in SIDE_G, when captured at entry.
- Pedestrian handling:
  - ped_req sets ped_pending.
  - On the ALLRED_A→SIDE_G transition, walk is captured as ped_pending|ped_req and ped_pending clears. A ped_req on that exact cycle is served, not left pending.
  - ped_req at any other time, including during SIDE_G, stays pending for the next cycle.
- enable=0: state, timer, walk and ped_pending hold. ped_req is still latched.
- Outputs are a pure decode of the state and timer registers; no combinational input→output paths.

## Timing
- Reset values: state ALLRED_B, remaining=T_ALLRED, main_lt=side_lt=3'b100, walk=0, ped_pending=0, phase=ALLRED_B code.
- Reset asserted mid-phase returns to these values immediately, asynchronously.
- A phase of duration T lasts exactly T enabled cycles. remaining reads T, T-1, …, 1, and the new state appears on the next edge.
- With defaults, first MAIN_G begins one cycle after reset release.
- Demand latency: car_side rising while MAIN_G is expired causes MAIN_Y on the next edge.
- Simultaneous expiry and enable=0: the freeze wins.

## Structure
- Package traffic_pkg holds:
  - state encoding constants (MAIN_G=0 … ALLRED_B=5);
  - lamp constants LT_R=3'b100, LT_Y=3'b010, LT_G=3'b001.
- Sub-module phase_timer: W-bit loadable down-counter with inputs load, value, en, and outputs remaining, expired (remaining==1).
- The FSM, pedestrian latch and lamp decode live in the top module.

## Test plan
All scenarios use T_GMIN=4, T_YEL=2, T_ALLRED=1, T_SIDE=3, T_WALK=5.
1. Reset, no demand for 50 cycles → one ALLRED_B cycle, then MAIN_G forever, with remaining counting 4,3,2,1 then stuck at 1.
2. car_side held high → full loop of MAIN_G 4, MAIN_Y 2, ALLRED_A 1, SIDE_G 3, SIDE_Y 2, ALLRED_B 1 cycles (13-cycle period), with walk=0 throughout.
3. One ped_req pulse during MAIN_G, car_side=0 → ped_pending=1, MAIN_Y after expiry, SIDE_G lasts 5 cycles with walk=1, ped_pending=0 from SIDE_G entry.
4. ped_req on the exact ALLRED_A→SIDE_G edge → walk=1 in that SIDE_G and ped_pending stays 0. A second ped_req during SIDE_G → ped_pending=1 carried to the next cycle.
5. enable=0 for 7 cycles in the middle of MAIN_Y at remaining=2 → state and remaining frozen at 2, with MAIN_Y resuming for 2 more cycles afterwards.
6. reset pulsed during SIDE_G with walk=1 → immediate ALLRED_B, both lamps R, walk=0, ped_pending=0, remaining=1.
